md_unit_param: RTL and testbench
================================

// Module: md_unit_param
// PURPOSE
//  Parametrised multiply/divide unit for the EX stage of the 5-stage pipeline.
//  It is the successor to the fixed 32-bit HI/LO unit, with configurable width and latencies.
//  It adds a cancel input (flush/exception), a one-cycle done pulse, and defined div-by-zero
//  and signed-overflow results. The hazard unit stalls on busy|start; HI/LO feed the mfhi/mflo path.
// PARAMETERS
//  WIDTH       32  operand and HI/LO width
//  MUL_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES  10  busy cycles for div/divu (>=1)
// PORTS
//  clk     in   1      clock; all state updates on the rising edge
//  reset   in   1      asynchronous, active-low reset
//  start   in   1      launch op (qualified only in IDLE)
//  op      in   3      000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others nop
//  a       in   WIDTH  rs operand (forwarded)
//  b       in   WIDTH  rt operand (forwarded)
//  cancel  in   1      abort the in-flight op; suppresses start/move in the same cycle
//  busy    out  1      high while an op is in flight
//  done    out  1      1-cycle pulse in the cycle HI/LO become valid after an op
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, pending regs=0.
//  Two states, IDLE and BUSY.
//  IDLE:
//   - start & op in {000..011} & !cancel:
//     . compute result into pend_hi/pend_lo
//     . load cnt = MUL_CYCLES (mult/multu) or DIV_CYCLES (div/divu)
//     . go to BUSY
//   - start & op=100/101 & !cancel: hi<=a / lo<=a at this edge; stay IDLE; busy stays 0; no done.
//   - start with op 110/111: no effect.
//  BUSY:
//   - cnt decrements each cycle.
//   - On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, state<=IDLE, done<=1 for exactly one cycle.
//   - start is ignored while BUSY (no queueing); the hazard unit guarantees no issue.
//  Timing: start sampled at edge t.
//   - busy=1 for cycles t+1..t+N.
//   - new hi/lo and done=1 in cycle t+N+1, busy=0 in that same cycle.
//   - a back-to-back start in cycle t+N+1 is accepted.
//  Arithmetic:
//   - mult: signed 2W product; hi=[2W-1:W], lo=[W-1:0]. multu: the same, unsigned.
//   - div: lo=quotient truncated toward zero; hi=remainder, sign of dividend. divu: unsigned.
//   - b==0 (div/divu): hi/lo keep their old values; busy/done timing unchanged.
//   - div with a=MIN, b=-1: lo=MIN, hi=0 (no trap).
//  cancel:
//   - In BUSY: return to IDLE next edge, hi/lo unchanged, no done, cnt cleared.
//   - In IDLE: any start/move in the same cycle is dropped.
//  Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1); no wrap is possible.
//  hi/lo change only on a move, on op completion, or on reset.
//  Async reset mid-op: immediate return to IDLE, all outputs 0.
// TESTING
//  1) reset low then release; start mult a=-3 b=7 (W=32,N=5) -> busy 5 cycles;
//     then hi=FFFFFFFF, lo=FFFFFFEB, done 1 cycle.
//  2) divu a=100 b=7 -> after 10 busy cycles lo=14, hi=2.
//     div a=-7 b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  3) mthi a=1234, then mtlo a=5678 -> hi=1234 and lo=5678 the next cycle, busy never high.
//     div b=0 -> hi/lo still 1234/5678 after completion, done pulses.
//  4) div a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
//     start asserted on a BUSY cycle with op=mthi -> ignored, hi unchanged.
//  5) mult started, cancel on the 3rd busy cycle -> busy=0 next cycle, no done, hi/lo unchanged.
//     start+cancel same cycle -> nothing happens.
//  6) reset asserted mid-divide -> busy=0, hi=lo=0 immediately.
//     Re-run with WIDTH=16, MUL_CYCLES=1: multu FFFF*FFFF -> hi=FFFE, lo=0001 after 1 busy cycle.

Source files
------------

// File: rtl/md_unit_param.sv
// Multiply/divide unit for the EX stage with parametrised width and latencies.
// It launches from IDLE and commits HI/LO with a one-cycle done pulse after a fixed busy window.
module md_unit_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_pend_hi;
    logic [WIDTH-1:0]   r_pend_lo;
    logic               r_pend_wr;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic [2*WIDTH-1:0] w_mul_a;
    logic [2*WIDTH-1:0] w_mul_b;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_dvd;
    logic [WIDTH-1:0]   w_dvs;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // op[0] clear selects the signed flavour for both mult and div.
    assign w_signed = ~op[0];

    // Sign-extending to 2W makes a single unsigned multiplier serve both flavours.
    assign w_mul_a = {{WIDTH{w_signed & a[WIDTH-1]}}, a};
    assign w_mul_b = {{WIDTH{w_signed & b[WIDTH-1]}}, b};
    assign w_prod  = w_mul_a * w_mul_b;

    // NOTE: signed divide is done on magnitudes so MIN / -1 wraps to MIN with remainder 0
    // instead of relying on a signed '/' whose overflow behaviour is tool-dependent.
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_b_zero = (b == '0);
    assign w_dvd    = w_a_neg ? -a : a;
    assign w_dvs    = w_b_zero ? WIDTH'(1) : (w_b_neg ? -b : b);
    assign w_uq     = w_dvd / w_dvs;
    assign w_ur     = w_dvd % w_dvs;
    assign w_quot   = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
    assign w_rem    = w_a_neg ? -w_ur : w_ur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_pend_hi <= w_prod[2*WIDTH-1:WIDTH];
                                r_pend_lo <= w_prod[WIDTH-1:0];
                                r_pend_wr <= 1'b1;
                                r_cnt     <= CNT_W'(MUL_CYCLES);
                                r_state   <= S_BUSY;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_pend_hi <= w_rem;
                                r_pend_lo <= w_quot;
                                r_pend_wr <= ~w_b_zero;
                                r_cnt     <= CNT_W'(DIV_CYCLES);
                                r_state   <= S_BUSY;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    if (cancel) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_W'(1)) begin
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_BUSY);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_md_unit_param.sv
// Scoreboard bench for md_unit_param: directed ops push expected HI/LO, monitors pop on done.
// A 32-bit instance covers the main behaviour; a 16-bit single-cycle-multiply instance covers the re-parametrised run.
module tb_md_unit_param;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, cancel, busy, done;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;

    logic        reset16, start16, cancel16, busy16, done16;
    logic [2:0]  op16;
    logic [15:0] a16, b16, hi16, lo16;

    logic [63:0] q32[$];
    logic [63:0] q16[$];
    logic [63:0] m32_exp, m16_exp;
    int n_cmp = 0;
    int n_bad = 0;

    md_unit_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    md_unit_param #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
        .clk(clk), .reset(reset16), .start(start16), .op(op16), .a(a16), .b(b16), .cancel(cancel16),
        .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (q32.size() == 0) begin
                check("done32_unexpected", {63'b0, done}, 64'd0);
            end else begin
                m32_exp = q32.pop_front();
                check("hilo32", {hi, lo}, m32_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (reset16 && done16) begin
            if (q16.size() == 0) begin
                check("done16_unexpected", {63'b0, done16}, 64'd0);
            end else begin
                m16_exp = q16.pop_front();
                check("hilo16", {32'b0, hi16, lo16}, m16_exp);
            end
        end
    end

    // Called just after a falling edge; returns at the falling edge of the first non-busy cycle.
    task automatic run32(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                         input logic [31:0] e_hi, input logic [31:0] e_lo, input int e_cyc,
                         input bit push, input int poke_at, input int cancel_at,
                         input logic [31:0] hold_hi);
        int cyc;
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        if (push) q32.push_back({e_hi, e_lo});
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (poke_at != 0 && cyc == poke_at + 1)
                check("hi_hold_busy", {32'b0, hi}, {32'b0, hold_hi});
            start = (cyc == poke_at);
            if (cyc == poke_at) begin
                op = OP_MTHI;
                a  = 32'hDEADBEEF;
            end
            cancel = (cyc == cancel_at);
            @(negedge clk);
        end
        start  = 1'b0;
        cancel = 1'b0;
        check("busy_cycles32", 64'(cyc), 64'(e_cyc));
    endtask

    task automatic move32(input logic [2:0] t_op, input logic [31:0] t_a);
        start = 1'b1; op = t_op; a = t_a;
        @(negedge clk);
        start = 1'b0;
        check("move_busy", {63'b0, busy}, 64'd0);
    endtask

    task automatic run16(input logic [2:0] t_op, input logic [15:0] t_a, input logic [15:0] t_b,
                         input logic [15:0] e_hi, input logic [15:0] e_lo, input int e_cyc);
        int cyc;
        start16 = 1'b1; op16 = t_op; a16 = t_a; b16 = t_b;
        q16.push_back({32'b0, e_hi, e_lo});
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0;
        while (busy16 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("busy_cycles16", 64'(cyc), 64'(e_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        reset16 = 1'b1; start16 = 1'b0; cancel16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        #1;
        reset = 1'b0; reset16 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_hilo16", {32'b0, hi16, lo16}, 64'd0);
        reset = 1'b1; reset16 = 1'b1;
        @(negedge clk);

        // Each run starts in the done cycle of the previous one, so back-to-back issue is exercised.
        run32(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5, 1, 0, 0, 32'd0);
        run32(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1, 0, 0, 32'd0);
        run32(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1, 0, 0, 32'd0);

        move32(OP_MTHI, 32'h1234);
        check("mthi_hi", {32'b0, hi}, 64'h1234);
        move32(OP_MTLO, 32'h5678);
        check("mtlo_hilo", {hi, lo}, {32'h1234, 32'h5678});

        run32(OP_DIV, 32'd9, 32'd0, 32'h1234, 32'h5678, 10, 1, 0, 0, 32'd0);
        run32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 1, 2, 0, 32'h1234);
        @(negedge clk);
        check("poke_ignored_hi", {hi, lo}, {32'd0, 32'h80000000});

        run32(OP_MULT, 32'd5, 32'd5, 32'd0, 32'd0, 3, 0, 0, 3, 32'd0);
        check("cancel_done", {63'b0, done}, 64'd0);
        check("cancel_hilo", {hi, lo}, {32'd0, 32'h80000000});

        start = 1'b1; cancel = 1'b1; op = OP_MTHI; a = 32'hCAFE;
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b1; cancel = 1'b0; op = 3'b110;
        @(negedge clk);
        start = 1'b0;
        check("startcancel_busy", {63'b0, busy}, 64'd0);
        check("startcancel_hilo", {hi, lo}, {32'd0, 32'h80000000});

        move32(OP_MTHI, 32'hAAAA);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", {63'b0, busy}, 64'd1);
        #2 reset = 1'b0;
        #1;
        check("midreset_busy", {63'b0, busy}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        check("midreset_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run32(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 5, 1, 0, 0, 32'd0);

        run16(OP_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1);
        run16(OP_MULT, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1);
        run16(OP_DIV, 16'hFFF7, 16'd4, 16'hFFFF, 16'hFFFE, 3);

        repeat (3) @(negedge clk);
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q16_drained", 64'(q16.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
